// File: rtl/rst_seq.sv
// rst_seq: reset sequencer downstream of the MMCM.
// Waits for synchronized lock to be stable for STABLE_CYCLES, then releases
// the NUM_OUTS core resets one at a time, RELEASE_GAP cycles apart, LSB first.
// Any lock loss after the stable window drops every core reset and is counted.
// Ports:
//   i_clk            - MMCM output clock (after BUFG)
//   i_reset_n        - async active-low reset, deassertion synchronized
//   i_locked         - MMCM LOCKED, asynchronous to i_clk
//   o_rst_n          - active-low core resets, bit 0 released first
//   o_ready          - all resets released and sequencer in RUN
//   o_lock_lost_cnt  - saturating count of lock losses in RELEASE/RUN
//   o_state          - debug state (WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3)
module rst_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned NUM_OUTS      = 3,
  parameter int unsigned RELEASE_GAP   = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_locked,
  output logic [NUM_OUTS-1:0] o_rst_n,
  output logic                o_ready,
  output logic [CNT_W-1:0]    o_lock_lost_cnt,
  output logic [1:0]          o_state
);

  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(RELEASE_GAP + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Internal reset: asserts with i_reset_n, deasserts after SYNC_STAGES edges
  logic [SYNC_STAGES-1:0] rst_sync;
  logic                   rst_int_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= '0;
    else            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_int_n = rst_sync[SYNC_STAGES-1];

  // Lock synchronizer
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) lock_sync <= '0;
    else            lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_locked};
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

  // Sequencer state and registered outputs
  state_t                state, state_nxt;
  logic [STB_W-1:0]      stb_cnt, stb_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_nxt;
  logic [NUM_OUTS-1:0]   rst_nxt;
  logic                  ready_nxt;
  logic [CNT_W-1:0]      lost_nxt;

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state           <= WAIT_LOCK;
      stb_cnt         <= '0;
      gap_cnt         <= '0;
      o_rst_n         <= '0;
      o_ready         <= 1'b0;
      o_lock_lost_cnt <= '0;
    end else begin
      state           <= state_nxt;
      stb_cnt         <= stb_nxt;
      gap_cnt         <= gap_nxt;
      o_rst_n         <= rst_nxt;
      o_ready         <= ready_nxt;
      o_lock_lost_cnt <= lost_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    stb_nxt   = stb_cnt;
    gap_nxt   = gap_cnt;
    rst_nxt   = o_rst_n;
    ready_nxt = o_ready;
    lost_nxt  = o_lock_lost_cnt;

    if ((state == RELEASE || state == RUN) && !lock_s) begin
      // Lock lost after the stable window: drop everything and count it
      state_nxt = WAIT_LOCK;
      stb_nxt   = '0;
      gap_nxt   = '0;
      rst_nxt   = '0;
      ready_nxt = 1'b0;
      if (o_lock_lost_cnt != {CNT_W{1'b1}}) lost_nxt = o_lock_lost_cnt + CNT_W'(1);
    end else begin
      case (state)
        WAIT_LOCK: begin
          stb_nxt   = '0;
          gap_nxt   = '0;
          rst_nxt   = '0;
          ready_nxt = 1'b0;
          // The edge leaving WAIT_LOCK is the first cycle of the stable window
          if (lock_s) begin
            if (STABLE_CYCLES == 1) begin
              state_nxt = RELEASE;
              rst_nxt   = NUM_OUTS'(1);
            end else begin
              state_nxt = STABLE;
              stb_nxt   = STB_W'(1);
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            stb_nxt   = '0;
          end else if (stb_cnt == STB_W'(STABLE_CYCLES - 1)) begin
            state_nxt = RELEASE;
            stb_nxt   = '0;
            gap_nxt   = '0;
            rst_nxt   = NUM_OUTS'(1);
          end else begin
            stb_nxt = stb_cnt + STB_W'(1);
          end
        end
        RELEASE: begin
          if (o_rst_n[NUM_OUTS-1]) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else if (gap_cnt == GAP_W'(RELEASE_GAP - 1)) begin
            gap_nxt = '0;
            rst_nxt = (o_rst_n << 1) | NUM_OUTS'(1);
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          ready_nxt = 1'b1;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule
